// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables, write-lane placement, read extraction
// and alignment/size legality for one access within an aligned word.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_offset,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [3:0]        o_be_c,
  output logic [DATA_W-1:0] o_wlane_c,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic              o_bad_c
);

  logic [1:0]        w_byte_lane;
  logic [1:0]        w_half_lane;
  logic [4:0]        w_sh_byte;
  logic [4:0]        w_sh_half;
  logic [DATA_W-1:0] w_rword_byte;
  logic [DATA_W-1:0] w_rword_half;

  // Byte at offset o sits (3-o) bytes above the LSB; a half at o sits (2-o) above.
  assign w_byte_lane  = ~i_offset;
  assign w_half_lane  = 2'd2 - i_offset;
  assign w_sh_byte    = {w_byte_lane, 3'b000};
  assign w_sh_half    = {w_half_lane, 3'b000};
  assign w_rword_byte = i_rword >> w_sh_byte;
  assign w_rword_half = i_rword >> w_sh_half;

  always_comb begin
    o_be_c    = 4'b0000;
    o_wlane_c = '0;
    o_rdata_c = '0;
    o_bad_c   = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be_c    = 4'b0001 << i_offset;
        o_wlane_c = {24'd0, i_wdata[7:0]} << w_sh_byte;
        o_rdata_c = {24'd0, w_rword_byte[7:0]};
      end
      SZ_HALF: begin
        o_bad_c   = i_offset[0];
        o_be_c    = 4'b0011 << i_offset;
        o_wlane_c = {16'd0, i_wdata[15:0]} << w_sh_half;
        o_rdata_c = {16'd0, w_rword_half[15:0]};
      end
      SZ_WORD: begin
        o_bad_c   = (i_offset != 2'd0);
        o_be_c    = 4'b1111;
        o_wlane_c = i_wdata;
        o_rdata_c = i_rword;
      end
      default: o_bad_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Variable-latency byte-addressed memory responder with request/response
// valid/ready handshakes and misalignment/range error reporting.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;

  state_e            r_state;
  state_e            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_accept;
  logic              w_access;
  logic              w_release;

  logic              r_write;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [7:0]        r_mem [MEM_BYTES];
  logic [DATA_W-1:0] w_rword;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wlane;
  logic [DATA_W-1:0] w_rdata;
  logic              w_bad;
  logic              w_range_err;
  logic              w_err;

  // State and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_W'(WAIT_CYCLES);
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_access     = 1'b1;
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  mem_lane_align u_align (
    .i_size    (r_size),
    .i_offset  (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rword   (w_rword),
    .o_be_c    (w_be),
    .o_wlane_c (w_wlane),
    .o_rdata_c (w_rdata),
    .o_bad_c   (w_bad)
  );

  // Aligned accesses never straddle a word, so the base address alone decides range.
  assign w_range_err = ((r_addr >> ADDR_W) != '0);
  assign w_err       = w_bad | w_range_err;

  always_comb begin
    w_rword = '0;
    for (int k = 0; k < 4; k++) begin
      w_rword[31-8*k -: 8] = r_mem[{r_addr[ADDR_W-1:2], 2'(k)}];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_access && !w_err && r_write) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[{r_addr[ADDR_W-1:2], 2'(k)}] <= w_wlane[31-8*k -: 8];
        end
      end
    end
  end

  // Request latch, registered response and handshake flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write     <= 1'b0;
      r_size      <= SZ_BYTE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? '0 : w_rdata;
      end else if (w_release) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
      r_req_ready <= (w_state_next == IDLE);
      r_rsp_valid <= (w_state_next == RESP);
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a byte-array reference model.
module tb_mem_responder;

  localparam int unsigned W   = 2;
  localparam int unsigned MEM = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

  logic [7:0]  model_mem [MEM];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_size(req_size0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: legality by arithmetic on the address, big-endian byte gather/scatter.
  task automatic model_txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n;
    longint unsigned end_addr;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    end_addr = longint'(a) + longint'(n);
    e = (s == 2'd3) || ((a % n) != 0) || (end_addr > MEM);
    rd = 32'd0;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        if (w) model_mem[a + i] = 8'(wd >> (8 * (n - 1 - i)));
        else   rd = (rd << 8) | 32'(model_mem[a + i]);
      end
    end
  endtask

  task automatic do_txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input bit pulse);
    logic [31:0] exp_rd;
    logic        exp_e;
    int          cyc;
    model_txn(w, s, a, wd, exp_rd, exp_e);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b1; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(W + 1));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h14; req_wdata = 32'hBADBADBA;
      end
      if (pulse && i == 3) req_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_rdata", rsp_rdata, 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_txn0(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
    req_valid0 = 1'b1; req_write0 = w; req_size0 = 2'd2; req_addr0 = a; req_wdata0 = wd;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_not_yet", 32'(rsp_valid0), 32'd0);
    @(posedge clk); #1;
    chk("w0_latency", 32'(rsp_valid0), 32'd1);
    chk("w0_rdata", rsp_rdata0, exp_rd);
    chk("w0_err", 32'(rsp_err0), 32'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    chk("w0_req_ready", 32'(req_ready0), 32'd1);
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] a;
    for (int i = 0; i < MEM; i++) model_mem[i] = 8'd0;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'd0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed plan
    do_txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0);
    chk("plan_deadbeef", rsp_rdata, 32'd0);
    do_txn(1'b1, 2'd0, 32'h11, 32'h000000AA, 0, 1'b0);
    do_txn(1'b0, 2'd1, 32'h10, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'd0, 32'h13, 32'h0, 0, 1'b0);
    do_txn(1'b1, 2'd2, 32'h14, 32'h01020304, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'h12, 32'h0, 0, 1'b0);
    do_txn(1'b1, 2'd1, 32'h15, 32'hFFFF, 0, 1'b0);
    do_txn(1'b1, 2'd3, 32'h14, 32'hFFFFFFFF, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'h14, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 1'b0);
    do_txn(1'b1, 2'd2, 32'hFC, 32'hA5A55A5A, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'hFC, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, 5, 1'b1);
    do_txn(1'b0, 2'd2, 32'h14, 32'h0, 0, 1'b0);

    // Zero wait states
    do_txn0(1'b1, 32'h40, 32'hCAFEF00D, 32'h0);
    do_txn0(1'b0, 32'h40, 32'h0, 32'hCAFEF00D);

    // Randomized traffic
    for (int t = 0; t < 120; t++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom_range(250, 300);
      else a = 32'($urandom_range(0, 63) * 4) + 32'((s == 2'd0) ? $urandom_range(0, 3) :
                                                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) :
                                                   (s == 2'd1) ? 2 * $urandom_range(0, 1) : 0);
      do_txn(1'($urandom_range(0, 1)), s, a, $urandom, $urandom_range(0, 2), 1'b0);
    end

    // Reset while a store waits to commit
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < MEM; i++) model_mem[i] = 8'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 2'd2, 32'h20, 32'h0, 0, 1'b0);
    chk("midrst_load", rsp_rdata, 32'd0);
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
